// File: rtl/sobel_window_ctrl_pkg.sv
// Shared constants and state encoding for the Sobel 3x3 window controller.
package sobel_window_ctrl_pkg;

    localparam int SW_DATA_W   = 8;
    localparam int SW_LINE_MAX = 1024;
    localparam int SW_COL_W    = 10;
    localparam int SW_ROW_W    = 11;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        IN_FRAME   = 2'd1,
        LINE       = 2'd2,
        LINE_END   = 2'd3
    } sw_state_t;

    // Row counter stops at all-ones instead of wrapping.
    function automatic logic [SW_ROW_W-1:0] row_sat_inc(input logic [SW_ROW_W-1:0] r);
        return (r == {SW_ROW_W{1'b1}}) ? r : r + 1'b1;
    endfunction

endpackage

// File: rtl/sobel_window_row.sv
// One row of the 3x3 window: 3-deep shift register, tap3 is the newest pixel.
module sobel_window_row
    import sobel_window_ctrl_pkg::*;
#(
    parameter int DATA_W = SW_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] tap1,
    output logic [DATA_W-1:0] tap2,
    output logic [DATA_W-1:0] tap3
);

    // Clear has priority; otherwise shift left on strobe, hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap1 <= '0;
            tap2 <= '0;
            tap3 <= '0;
        end else if (clr) begin
            tap1 <= '0;
            tap2 <= '0;
            tap3 <= '0;
        end else if (shift_en) begin
            tap1 <= tap2;
            tap2 <= tap3;
            tap3 <= din;
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sobel 3x3 window controller: drives an external 2-line shift RAM, builds the
// window from its taps and tracks frame/line position and line-length errors.
//
// state      | meaning
// -----------+----------------------------------------------------------
// WAIT_FRAME | after reset, ignore everything until the first vsync rise
// IN_FRAME   | inside a frame, waiting for a line (href rise)
// LINE       | href high, pixels are being counted
// LINE_END   | one clock after href fall, row counter advances
module sobel_window_ctrl
    import sobel_window_ctrl_pkg::*;
#(
    parameter int DATA_W   = SW_DATA_W,
    parameter int LINE_MAX = SW_LINE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_y,
    output logic              ls_clken,
    output logic              ls_href,
    output logic [DATA_W-1:0] ls_shiftin,
    input  logic [DATA_W-1:0] ls_taps0x,
    input  logic [DATA_W-1:0] ls_taps1x,
    output logic              matrix_frame_vsync,
    output logic              matrix_frame_href,
    output logic              matrix_frame_clken,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p13,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22,
    output logic [DATA_W-1:0] matrix_p23,
    output logic [DATA_W-1:0] matrix_p31,
    output logic [DATA_W-1:0] matrix_p32,
    output logic [DATA_W-1:0] matrix_p33,
    output logic              win_valid,
    output logic              line_err
);

    localparam logic [SW_COL_W-1:0] COL_LAST = SW_COL_W'(LINE_MAX - 1);
    localparam logic [SW_COL_W-1:0] COL_TWO  = SW_COL_W'(2);
    localparam logic [SW_ROW_W-1:0] ROW_TWO  = SW_ROW_W'(2);

    sw_state_t           state, state_nxt;
    logic                vsync_q, href_q;
    logic                vsync_rise, href_rise, href_fall;
    logic                frame_ok, line_ok;
    logic [SW_COL_W-1:0] col_cnt, ref_len, pix_col;
    logic [SW_ROW_W-1:0] row_cnt, pix_row;
    logic                pos_ok;
    logic                vsync_d1, vsync_d2, href_d1, href_d2, clken_d1, clken_d2;
    logic                ok_d1;
    logic [DATA_W-1:0]   row3_d;
    logic                win_clr;

    assign ls_clken   = per_frame_clken & per_frame_href;
    assign ls_href    = per_frame_href;
    assign ls_shiftin = per_img_y;

    assign vsync_rise = per_frame_vsync & ~vsync_q;
    assign href_rise  = per_frame_href & ~href_q;
    assign href_fall  = ~per_frame_href & href_q;

    // Nothing is reported until a vsync has been seen since reset; a vsync
    // arriving mid-line drops the rest of that partial line.
    assign frame_ok = (state != WAIT_FRAME) | vsync_rise;
    assign line_ok  = ((state == LINE) & ~vsync_rise) | (href_rise & frame_ok);
    assign win_clr  = href_rise & frame_ok;

    // Position of the pixel arriving this clock; edges restart the counts.
    assign pix_row = vsync_rise ? '0 : row_cnt;
    assign pix_col = (href_rise | vsync_rise) ? '0 : col_cnt;
    assign pos_ok  = (pix_row >= ROW_TWO) && (pix_col >= COL_TWO);

    // Previous-cycle sync levels for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= per_frame_vsync;
            href_q  <= per_frame_href;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_FRAME;
        else        state <= state_nxt;
    end

    // FSM next state; a vsync rise restarts the frame from any state.
    always_comb begin
        state_nxt = state;
        if (vsync_rise) begin
            state_nxt = href_rise ? LINE : IN_FRAME;
        end else begin
            case (state)
                WAIT_FRAME: state_nxt = WAIT_FRAME;
                IN_FRAME:   if (href_rise) state_nxt = LINE;
                LINE:       if (href_fall) state_nxt = LINE_END;
                LINE_END:   state_nxt = href_rise ? LINE : IN_FRAME;
                default:    state_nxt = WAIT_FRAME;
            endcase
        end
    end

    // Column/row counters, reference line length and sticky line error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            ref_len  <= '0;
            line_err <= 1'b0;
        end else if (vsync_rise) begin
            col_cnt  <= {{(SW_COL_W-1){1'b0}}, href_rise & ls_clken};
            row_cnt  <= '0;
            ref_len  <= '0;
            line_err <= 1'b0;
        end else if (state != WAIT_FRAME) begin
            if (href_rise) begin
                col_cnt <= {{(SW_COL_W-1){1'b0}}, ls_clken};
            end else if (ls_clken && state == LINE) begin
                if (col_cnt == COL_LAST) line_err <= 1'b1;
                else                     col_cnt  <= col_cnt + 1'b1;
            end
            if (state == LINE && href_fall) begin
                if (row_cnt == '0)             ref_len  <= col_cnt;
                else if (col_cnt != ref_len)   line_err <= 1'b1;
            end
            if (state == LINE_END) row_cnt <= row_sat_inc(row_cnt);
        end
    end

    // Two-stage sync delay, row-3 pixel alignment and window-valid tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d1  <= 1'b0;
            vsync_d2  <= 1'b0;
            href_d1   <= 1'b0;
            href_d2   <= 1'b0;
            clken_d1  <= 1'b0;
            clken_d2  <= 1'b0;
            ok_d1     <= 1'b0;
            row3_d    <= '0;
            win_valid <= 1'b0;
        end else begin
            vsync_d1  <= per_frame_vsync;
            vsync_d2  <= vsync_d1;
            href_d1   <= per_frame_href & line_ok;
            href_d2   <= href_d1;
            clken_d1  <= ls_clken & line_ok;
            clken_d2  <= clken_d1;
            ok_d1     <= pos_ok;
            row3_d    <= per_img_y;
            win_valid <= clken_d1 & ok_d1;
        end
    end

    assign matrix_frame_vsync = vsync_d2;
    assign matrix_frame_href  = href_d2;
    assign matrix_frame_clken = clken_d2;

    sobel_window_row #(.DATA_W(DATA_W)) u_row1 (
        .clk(clk), .rst_n(rst_n), .clr(win_clr), .shift_en(clken_d1),
        .din(ls_taps1x), .tap1(matrix_p11), .tap2(matrix_p12), .tap3(matrix_p13)
    );

    sobel_window_row #(.DATA_W(DATA_W)) u_row2 (
        .clk(clk), .rst_n(rst_n), .clr(win_clr), .shift_en(clken_d1),
        .din(ls_taps0x), .tap1(matrix_p21), .tap2(matrix_p22), .tap3(matrix_p23)
    );

    sobel_window_row #(.DATA_W(DATA_W)) u_row3 (
        .clk(clk), .rst_n(rst_n), .clr(win_clr), .shift_en(clken_d1),
        .din(row3_d), .tap1(matrix_p31), .tap2(matrix_p32), .tap3(matrix_p33)
    );

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl: external 2-line shift RAM model, image-based
// window reference, timing and line-error scenarios.
module tb_sobel_window_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       per_frame_vsync = 1'b0;
    logic       per_frame_href = 1'b0;
    logic       per_frame_clken = 1'b0;
    logic [7:0] per_img_y = 8'h00;
    logic       ls_clken, ls_href;
    logic [7:0] ls_shiftin;
    logic [7:0] ls_taps0x = 8'h00;
    logic [7:0] ls_taps1x = 8'h00;
    logic       matrix_frame_vsync, matrix_frame_href, matrix_frame_clken;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;
    logic       win_valid, line_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sobel_window_ctrl #(.DATA_W(8), .LINE_MAX(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
        .ls_clken(ls_clken), .ls_href(ls_href), .ls_shiftin(ls_shiftin),
        .ls_taps0x(ls_taps0x), .ls_taps1x(ls_taps1x),
        .matrix_frame_vsync(matrix_frame_vsync), .matrix_frame_href(matrix_frame_href),
        .matrix_frame_clken(matrix_frame_clken),
        .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
        .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
        .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33),
        .win_valid(win_valid), .line_err(line_err)
    );

    // Two-line shift RAM: address cleared while href is low, taps one clock late.
    logic [7:0] ram0 [0:1023];
    logic [7:0] ram1 [0:1023];
    int         ram_addr = 0;
    always @(posedge clk) begin
        if (!ls_href) begin
            ram_addr <= 0;
        end else if (ls_clken) begin
            ls_taps0x <= ram0[ram_addr];
            ls_taps1x <= ram1[ram_addr];
            ram1[ram_addr] <= ram0[ram_addr];
            ram0[ram_addr] <= ls_shiftin;
            ram_addr <= (ram_addr + 1) % 1024;
        end
    end

    // Record every window presented on a matrix strobe.
    typedef struct packed {
        logic [8:0][7:0] p;
        logic            wv;
    } obs_t;
    obs_t obs_q[$];
    obs_t obs_cur;
    int   bad_wv = 0;
    always @(negedge clk) begin
        if (win_valid && !matrix_frame_clken) bad_wv <= bad_wv + 1;
        if (matrix_frame_clken) begin
            obs_cur.p[0] = matrix_p11; obs_cur.p[1] = matrix_p12; obs_cur.p[2] = matrix_p13;
            obs_cur.p[3] = matrix_p21; obs_cur.p[4] = matrix_p22; obs_cur.p[5] = matrix_p23;
            obs_cur.p[6] = matrix_p31; obs_cur.p[7] = matrix_p32; obs_cur.p[8] = matrix_p33;
            obs_cur.wv   = win_valid;
            obs_q.push_back(obs_cur);
        end
    end

    logic [7:0] img [0:7][0:15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        per_frame_vsync = 1'b1;
        step();
        per_frame_vsync = 1'b0;
        step();
        step();
    endtask

    task automatic drive_line(input int r, input int len, input int gap);
        per_frame_href = 1'b1;
        for (int c = 0; c < len; c++) begin
            if (gap != 0) begin
                per_frame_clken = 1'b0;
                step();
                step();
            end
            per_frame_clken = 1'b1;
            per_img_y = (c < 16 && r < 8) ? img[r][c] : 8'($urandom);
            step();
        end
        per_frame_clken = 1'b0;
        per_frame_href  = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, win_valid, line_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, win_valid, line_err});
        end
        n_tests++;
        if ({matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23,
             matrix_p31, matrix_p32, matrix_p33} !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_window: got nonzero window expected all zero");
        end
        rst_n = 1'b1;
        step();
        step();
        n_tests++;
        if ({matrix_frame_clken, win_valid, line_err} !== 3'b0) begin
            n_fail++;
            $display("FAIL post_reset_flags: got %b expected 000", {matrix_frame_clken, win_valid, line_err});
        end
    endtask

    task automatic test_passthrough();
        per_frame_href = 1'b1; per_frame_clken = 1'b1; per_img_y = 8'h5A;
        #1;
        n_tests++;
        if ({ls_clken, ls_href, ls_shiftin} !== {1'b1, 1'b1, 8'h5A}) begin
            n_fail++;
            $display("FAIL passthru_on: got %b %b %h expected 1 1 5a", ls_clken, ls_href, ls_shiftin);
        end
        per_frame_clken = 1'b0;
        #1;
        n_tests++;
        if (ls_clken !== 1'b0) begin
            n_fail++;
            $display("FAIL passthru_noclk: got %b expected 0", ls_clken);
        end
        per_frame_href = 1'b0; per_frame_clken = 1'b1;
        #1;
        n_tests++;
        if ({ls_clken, ls_href} !== 2'b00) begin
            n_fail++;
            $display("FAIL passthru_nohref: got %b expected 00", {ls_clken, ls_href});
        end
        per_frame_clken = 1'b0;
        step();
        step();
    endtask

    // fill: 0 keep image, 1 ramp 16*row+col, 2 random
    task automatic test_window_frame(input int rows, input int width, input int gap, input int fill);
        int base, bad0, r, c, rr, cc;
        obs_t o;
        logic [7:0] expv;
        if (fill == 1) begin
            for (int i = 0; i < 8; i++) for (int j = 0; j < 16; j++) img[i][j] = 8'(16 * i + j);
        end else if (fill == 2) begin
            for (int i = 0; i < 8; i++) for (int j = 0; j < 16; j++) img[i][j] = 8'($urandom);
        end
        vsync_pulse();
        base = obs_q.size();
        bad0 = bad_wv;
        for (int i = 0; i < rows; i++) drive_line(i, width, gap);
        n_tests++;
        if (obs_q.size() - base != rows * width) begin
            n_fail++;
            $display("FAIL strobe_count: got %0d expected %0d", obs_q.size() - base, rows * width);
        end else begin
            for (int k = 0; k < rows * width; k++) begin
                o = obs_q[base + k];
                r = k / width;
                c = k % width;
                n_tests++;
                if (o.wv !== ((r >= 2 && c >= 2) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL win_valid r%0d c%0d: got %b expected %b", r, c, o.wv, (r >= 2 && c >= 2));
                end
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        rr = r - 2 + i;
                        cc = c - 2 + j;
                        if (rr >= 0) begin
                            expv = (cc < 0) ? 8'h00 : img[rr][cc];
                            n_tests++;
                            if (o.p[i * 3 + j] !== expv) begin
                                n_fail++;
                                $display("FAIL window r%0d c%0d p%0d%0d: got %h expected %h",
                                         r, c, i + 1, j + 1, o.p[i * 3 + j], expv);
                            end
                        end
                    end
                end
            end
            if (fill == 1 && rows >= 3 && width >= 3) begin
                o = obs_q[base + 2 * width + 2];
                n_tests++;
                if ({o.p[0], o.p[4], o.p[8], o.wv} !== {8'h00, 8'h11, 8'h22, 1'b1}) begin
                    n_fail++;
                    $display("FAIL ramp_r2c2: got p11=%h p22=%h p33=%h wv=%b expected 00 11 22 1",
                             o.p[0], o.p[4], o.p[8], o.wv);
                end
            end
        end
        n_tests++;
        if (bad_wv - bad0 != 0) begin
            n_fail++;
            $display("FAIL win_valid_outside_strobe: got %0d cycles expected 0", bad_wv - bad0);
        end
    endtask

    task automatic test_latency();
        logic [3:0] ck, hr, vs;
        vsync_pulse();
        per_frame_href = 1'b1; per_frame_clken = 1'b1; per_img_y = 8'h33;
        @(negedge clk); ck[3] = matrix_frame_clken; hr[3] = matrix_frame_href;
        @(posedge clk); #1;
        per_frame_href = 1'b0; per_frame_clken = 1'b0;
        @(negedge clk); ck[2] = matrix_frame_clken; hr[2] = matrix_frame_href;
        @(negedge clk); ck[1] = matrix_frame_clken; hr[1] = matrix_frame_href;
        @(negedge clk); ck[0] = matrix_frame_clken; hr[0] = matrix_frame_href;
        n_tests++;
        if (ck !== 4'b0010) begin
            n_fail++;
            $display("FAIL latency_clken: got %b expected 0010", ck);
        end
        n_tests++;
        if (hr !== 4'b0010) begin
            n_fail++;
            $display("FAIL latency_href: got %b expected 0010", hr);
        end
        @(posedge clk); #1;
        step();
        per_frame_vsync = 1'b1;
        @(negedge clk); vs[3] = matrix_frame_vsync;
        @(posedge clk); #1;
        per_frame_vsync = 1'b0;
        @(negedge clk); vs[2] = matrix_frame_vsync;
        @(negedge clk); vs[1] = matrix_frame_vsync;
        @(negedge clk); vs[0] = matrix_frame_vsync;
        n_tests++;
        if (vs !== 4'b0010) begin
            n_fail++;
            $display("FAIL latency_vsync: got %b expected 0010", vs);
        end
        @(posedge clk); #1;
        step();
    endtask

    task automatic test_line_len();
        vsync_pulse();
        drive_line(0, 8, 0);
        drive_line(1, 8, 0);
        n_tests++;
        if (line_err !== 1'b0) begin
            n_fail++;
            $display("FAIL line_err_equal: got %b expected 0", line_err);
        end
        drive_line(2, 7, 0);
        n_tests++;
        if (line_err !== 1'b1) begin
            n_fail++;
            $display("FAIL line_err_short: got %b expected 1", line_err);
        end
        per_frame_vsync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (line_err !== 1'b0) begin
            n_fail++;
            $display("FAIL line_err_clear: got %b expected 0", line_err);
        end
        @(posedge clk); #1;
        per_frame_vsync = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        vsync_pulse();
        per_frame_href = 1'b1;
        per_frame_clken = 1'b1;
        for (int c = 0; c < 1023; c++) begin
            per_img_y = 8'($urandom);
            step();
        end
        n_tests++;
        if ({line_err, dut.col_cnt} !== {1'b0, 10'd1023}) begin
            n_fail++;
            $display("FAIL overflow_edge: got err=%b col=%0d expected err=0 col=1023", line_err, dut.col_cnt);
        end
        for (int c = 0; c < 7; c++) begin
            per_img_y = 8'($urandom);
            step();
        end
        per_frame_clken = 1'b0;
        per_frame_href = 1'b0;
        step();
        step();
        n_tests++;
        if ({line_err, dut.col_cnt} !== {1'b1, 10'd1023}) begin
            n_fail++;
            $display("FAIL overflow: got err=%b col=%0d expected err=1 col=1023", line_err, dut.col_cnt);
        end
    endtask

    task automatic test_reset_midline();
        int base;
        vsync_pulse();
        per_frame_href = 1'b1;
        per_frame_clken = 1'b1;
        repeat (4) step();
        n_tests++;
        if (matrix_frame_clken !== 1'b1) begin
            n_fail++;
            $display("FAIL midline_active: got %b expected 1", matrix_frame_clken);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({matrix_frame_href, matrix_frame_clken} !== 2'b00) begin
            n_fail++;
            $display("FAIL midline_reset: got %b expected 00", {matrix_frame_href, matrix_frame_clken});
        end
        step();
        step();
        rst_n = 1'b1;
        base = obs_q.size();
        repeat (4) step();
        per_frame_clken = 1'b0;
        per_frame_href = 1'b0;
        step();
        step();
        drive_line(0, 6, 0);
        n_tests++;
        if (obs_q.size() - base != 0) begin
            n_fail++;
            $display("FAIL no_frame_strobes: got %0d expected 0", obs_q.size() - base);
        end
        vsync_pulse();
        base = obs_q.size();
        drive_line(0, 6, 0);
        n_tests++;
        if (obs_q.size() - base != 6) begin
            n_fail++;
            $display("FAIL after_vsync_strobes: got %0d expected 6", obs_q.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_window_frame(4, 8, 0, 1);
        test_latency();
        test_line_len();
        test_overflow();
        test_window_frame(4, 8, 0, 2);
        test_window_frame(4, 8, 1, 0);
        test_reset_midline();
        for (int n = 0; n < 3; n++) begin
            test_window_frame(int'($urandom_range(3, 6)), int'($urandom_range(3, 12)),
                              int'($urandom_range(0, 1)), 2);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_window_ctrl.md
SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, pixel width; LINE_MAX, default 1024, maximum pixels per line (10-bit line-RAM address space).
REQ-002 clk  input  1  system/pixel clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 per_frame_vsync  input  1  frame sync, active high.
REQ-005 per_frame_href  input  1  line valid, active high.
REQ-006 per_frame_clken  input  1  pixel strobe; pixel valid only when href=1.
REQ-007 per_img_y  input  DATA_W  greyscale pixel.
REQ-008 ls_clken  output  1  pixel strobe to the 2-line shift RAM.
REQ-009 ls_href  output  1  line valid to the shift RAM; clears its address counter.
REQ-010 ls_shiftin  output  DATA_W  pixel to the shift RAM.
REQ-011 ls_taps0x / ls_taps1x  input  DATA_W each  previous / second-previous line, valid 1 clk after ls_clken.
REQ-012 matrix_frame_vsync / _href / _clken  output  1 each  sync aligned to the window.
REQ-013 matrix_p11..p13, p21..p23, p31..p33  output  DATA_W each  3x3 window; row 1 oldest line, column 3 newest pixel.
REQ-014 win_valid  output  1  window fully inside image (row>=2 and col>=2).
REQ-015 line_err  output  1  sticky: current frame has a line length mismatch or overflow.

Function
REQ-016 FSM states: WAIT_FRAME, IN_FRAME, LINE, LINE_END.
REQ-017 Transitions:
- WAIT_FRAME -> IN_FRAME on vsync rising edge.
- IN_FRAME -> LINE on href rising edge.
- LINE -> LINE_END on href falling edge.
- LINE_END -> IN_FRAME after 1 clk.
- Any state -> IN_FRAME on vsync rising edge: clears row_cnt, col_cnt, ref_len, line_err.
REQ-018 ls_clken = per_frame_clken & per_frame_href; ls_href = per_frame_href; ls_shiftin = per_img_y; all combinational pass-through (zero latency).
REQ-019 col_cnt (10 bit) increments on each ls_clken and clears at href rising edge; row_cnt (11 bit) increments in LINE_END and saturates at 2047.
REQ-020 Line length checks:
- First line of a frame sets ref_len.
- Any later line with a different length sets line_err.
- A col_cnt increment past LINE_MAX-1 sets line_err, and col_cnt holds at LINE_MAX-1.
REQ-021 Row 3 source: per_img_y registered 1 clk to align with the taps.
REQ-022 Window shift: on ls_clken delayed 1 clk, each window row shifts left by one and loads column 3 from {taps1x, taps0x, row3_d}.
REQ-023 Window hold: contents hold when the delayed strobe is 0.
REQ-024 Window clear: the window clears to 0 at href rising edge.
REQ-025 Sync alignment: matrix_frame_vsync/_href/_clken equal the inputs delayed exactly 2 clk.
REQ-026 win_valid: computed from row/col captured with the pixel; asserted only while matrix_frame_clken=1.
REQ-027 Simultaneous events:
- vsync rise together with href/clken: the frame restart wins and the pixel counts as row 0 col 0.
- href fall together with clken: that pixel is counted.
REQ-028 href rising while in WAIT_FRAME (mid-frame start after reset) is ignored until the first vsync.

Reset
REQ-029 On rst_n=0:
- State goes to WAIT_FRAME.
- All counters, ref_len, delay registers, window, matrix_* and win_valid go to 0.
- line_err goes to 0.
REQ-030 Reset asserted mid-line: matrix_frame_href/_clken return to 0 within the reset assertion; no partial line is reported after release.

Structure
REQ-031 Shared package holds DATA_W, LINE_MAX, the 11-bit row width, and the FSM state encoding (2-bit).
REQ-032 The shift RAM stays external; one sub-module, sobel_window_row (3-deep shift register with clear and hold), is instantiated three times.

Verification
REQ-033 The bench shall cover these scenarios:
- Reset, then an 8x4 ramp frame (pixel = 16*row+col) -> at row 2 col 2, p11=0x00, p22=0x11, p33=0x22, win_valid=1; win_valid=0 on rows 0-1 and cols 0-1.
- Latency: a single clken pulse -> matrix_frame_clken rises exactly 2 clk later; vsync/href also delayed by 2.
- Line lengths 8,8,7 -> line_err=1 after the 3rd href fall; clears at the next vsync rise.
- Line of 1030 pixels -> line_err=1; col_cnt holds at 1023.
- Reset pulse mid-line, then href with no vsync -> no matrix_frame_clken until the next vsync rising edge.
- clken gapped 1-of-3 within a line -> window contents identical to the gap-free case.
